// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, default depth and entry type for the fetch queue
//
// Purpose : common definitions for fetch_queue and fq_storage.
// Contents: FQ_XLEN / FQ_ILEN   address and instruction widths (32 bits)
//           FQ_DEPTH_DEFAULT    default number of queue entries
//           fq_entry_t          packed {pc, instr} pair held in each slot
//           fq_pc_plus4()       sequential-PC helper, wraps modulo 2^32

package fetch_pkg;

    localparam int FQ_XLEN          = 32;
    localparam int FQ_ILEN          = 32;
    localparam int FQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_ILEN-1:0] instr;
    } fq_entry_t;

    localparam int FQ_ENTRY_W = $bits(fq_entry_t);

    function automatic logic [FQ_XLEN-1:0] fq_pc_plus4(input logic [FQ_XLEN-1:0] pc);
        return pc + FQ_XLEN'(4);
    endfunction

endpackage

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - DEPTH x 64-bit entry array, one sync write port, one async read port
//
// Purpose : payload storage for fetch_queue. Contents are never reset; the
//           owner masks the read data whenever the addressed slot is invalid.
// Ports   : clk_i      rising-edge clock for the write port
//           wr_en_i    write strobe
//           wr_addr_i  write slot index
//           wr_data_i  {pc, instr} entry to store
//           rd_addr_i  read slot index
//           rd_data_o  entry at rd_addr_i, combinational

module fq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [PTR_W-1:0] wr_addr_i,
    input  fq_entry_t        wr_data_i,
    input  logic [PTR_W-1:0] rd_addr_i,
    output fq_entry_t        rd_data_o
);

    fq_entry_t mem_q [DEPTH];

    // No reset on the array: only the pointer/count logic in the owner
    // decides which slots are meaningful.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order {pc, instr} FIFO between fetch and decode
//
// Purpose : decouples the fetch stage from decode. Fetch sees ~f_ready as
//           its PC stall; a redirect (flush) discards everything queued
//           and the entry being presented in the same cycle.
// Ports   : clk, reset_n        clock, async active-low reset
//           f_valid/f_pc/f_instr/f_ready   fetch-side handshake
//           flush              discard all queued and incoming entries
//           d_valid/d_pc/d_pc_plus4/d_instr/d_ready   decode-side handshake
//           count              occupied entries, 0..DEPTH

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     f_valid,
    input  logic [FQ_XLEN-1:0]       f_pc,
    input  logic [FQ_ILEN-1:0]       f_instr,
    output logic                     f_ready,
    input  logic                     flush,
    output logic                     d_valid,
    output logic [FQ_XLEN-1:0]       d_pc,
    output logic [FQ_XLEN-1:0]       d_pc_plus4,
    output logic [FQ_ILEN-1:0]       d_instr,
    input  logic                     d_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic      enq;
    logic      deq;
    fq_entry_t wr_entry;
    fq_entry_t head_entry;

    // Both handshake flags come straight from the registered count, so
    // f_ready never sees d_ready: a full queue refuses the incoming entry
    // even when decode drains the head in the same cycle.
    assign f_ready = (count_q != FULL_CNT);
    assign d_valid = (count_q != '0);

    assign enq = f_valid & f_ready & ~flush;
    assign deq = d_valid & d_ready & ~flush;

    assign wr_entry.pc    = f_pc;
    assign wr_entry.instr = f_instr;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // Pointers are exactly log2(DEPTH) bits, so +1 wraps for free.
            if (enq) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (deq) begin
                rptr_d = rptr_q + 1'b1;
            end
            unique case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk_i     (clk),
        .wr_en_i   (enq),
        .wr_addr_i (wptr_q),
        .wr_data_i (wr_entry),
        .rd_addr_i (rptr_q),
        .rd_data_o (head_entry)
    );

    // Slot contents are unreset, so the head is forced to zero while empty;
    // because d_valid is derived from count_q, reset clears these at once.
    assign d_pc       = d_valid ? head_entry.pc : '0;
    assign d_instr    = d_valid ? head_entry.instr : '0;
    assign d_pc_plus4 = d_valid ? fq_pc_plus4(head_entry.pc) : '0;

    assign count = count_q;

endmodule
